// File: rtl/sequence_player.sv
// rtl/sequence_player.sv - Simon Says colour sequence player driven by an 8-bit LFSR.
// Optional abort input is compiled in when ABORT_EN is defined.
module sequence_player #(
    parameter int MAX_LEN    = 16,
    parameter int ON_CYCLES  = 8,
    parameter int OFF_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] seq_len,
    input  logic [7:0] seed,
`ifdef ABORT_EN
    input  logic       abort,
`endif
    output logic [1:0] colour_out,
    output logic       oe_out,
    output logic [3:0] step_idx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [4:0]       MAX_LEN_C = 5'(MAX_LEN);
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(OFF_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [4:0]       len_q, len_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [3:0]       step_q, step_d;
    logic [1:0]       colour_q, colour_d;
    logic             oe_q, oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             abort_w;
    logic [7:0]       lfsr_next;

`ifdef ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        len_d    = len_q;
        lfsr_d   = lfsr_q;
        step_d   = step_q;
        colour_d = colour_q;
        oe_d     = oe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                oe_d   = 1'b0;
                busy_d = 1'b0;
                if (start && (seq_len != 5'd0)) begin
                    len_d    = (seq_len > MAX_LEN_C) ? MAX_LEN_C : seq_len;
                    // A zero seed would lock the LFSR, so it is promoted to 1.
                    lfsr_d   = (seed == 8'h00) ? 8'h01 : seed;
                    colour_d = lfsr_d[1:0];
                    step_d   = 4'd0;
                    phase_d  = ON_LAST;
                    oe_d     = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ST_ON;
                end
            end
            ST_ON: begin
                if (phase_q == '0) begin
                    phase_d = OFF_LAST;
                    oe_d    = 1'b0;
                    state_d = ST_OFF;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            ST_OFF: begin
                if (phase_q != '0) begin
                    phase_d = phase_q - 1'b1;
                end else if ({1'b0, step_q} == (len_q - 5'd1)) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    lfsr_d   = lfsr_next;
                    colour_d = lfsr_next[1:0];
                    step_d   = step_q + 4'd1;
                    phase_d  = ON_LAST;
                    oe_d     = 1'b1;
                    state_d  = ST_ON;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort only cuts short an active step; DONE always finishes its pulse.
        if (abort_w && ((state_q == ST_ON) || (state_q == ST_OFF))) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            step_d  = 4'd0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            len_q    <= 5'd0;
            lfsr_q   <= 8'h01;
            step_q   <= 4'd0;
            colour_q <= 2'b00;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            len_q    <= len_d;
            lfsr_q   <= lfsr_d;
            step_q   <= step_d;
            colour_q <= colour_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign colour_out = colour_q;
    assign oe_out     = oe_q;
    assign step_idx   = step_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sequence_player.sv
// tb/tb_sequence_player.sv - table-driven bench for sequence_player (abort cases under ABORT_EN).
module tb_sequence_player;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [4:0] seq_len = 5'd0;
    logic [7:0] seed = 8'h00;
`ifdef ABORT_EN
    logic       abort = 1'b0;
`endif
    logic [1:0] colour_out;
    logic       oe_out;
    logic [3:0] step_idx;
    logic       busy;
    logic       done;

    int pass_cnt = 0;
    int total_cnt = 0;

    sequence_player dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .seq_len    (seq_len),
        .seed       (seed),
`ifdef ABORT_EN
        .abort      (abort),
`endif
        .colour_out (colour_out),
        .oe_out     (oe_out),
        .step_idx   (step_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] seed;
        logic [4:0] len;
        int         steps;
        logic [7:0] first4;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [1:0] model_colour(input logic [7:0] sd, input int s, input logic [7:0] first4);
        logic [7:0] l;
        if (s < 4) return first4[7-2*s -: 2];
        l = (sd == 8'h00) ? 8'h01 : sd;
        for (int i = 0; i < s; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        return l[1:0];
    endfunction

    function automatic logic [8:0] outs();
        return {colour_out, oe_out, step_idx, busy, done};
    endfunction

    // Entered at cycle 0 with the DUT idle; leaves it idle.
    task automatic run_seq(input int vi, input vec_t v, input bit repulse);
        int n, s, ph;
        logic [8:0] exp;
        n = v.steps;
        start = 1'b1; seq_len = v.len; seed = v.seed;
        tick();
        start = 1'b0; seq_len = 5'd7; seed = 8'h5A;
        for (int k = 1; k <= 2 + 12*n; k++) begin
            s  = (k - 1) / 12;
            if (s > n - 1) s = n - 1;
            ph = (k - 1) % 12;
            exp = {model_colour(v.seed, s, v.first4),
                   (k <= 12*n) && (ph < 8),
                   4'(s),
                   k <= 1 + 12*n,
                   k == 1 + 12*n};
            chk($sformatf("v%0d_r%0d_c%0d", vi, repulse, k), 32'(outs()), 32'(exp));
            if (repulse && (k == 15 || k == 1 + 12*n)) begin
                start = 1'b1; seq_len = 5'd4; seed = 8'hFF;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        vecs[0] = '{8'h01, 5'd4,  4,  8'b01_10_00_00};
        vecs[1] = '{8'h00, 5'd4,  4,  8'b01_10_00_00};
        vecs[2] = '{8'hA5, 5'd3,  3,  8'b01_10_01_10};
        vecs[3] = '{8'h03, 5'd1,  1,  8'b11_10_00_01};
        vecs[4] = '{8'hFF, 5'd20, 16, 8'b11_10_00_00};
        vecs[5] = '{8'hA5, 5'd16, 16, 8'b01_10_01_10};
        vecs[6] = '{8'h03, 5'd2,  2,  8'b11_10_00_01};

        reset = 1'b1;
        repeat (3) tick();
        chk("reset_state", 32'(outs()), 32'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_seq(i, vecs[i], 1'b0);
            tick();
        end

        run_seq(0, vecs[0], 1'b1);
        tick();

        start = 1'b1; seq_len = 5'd0; seed = 8'h01;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            start = (k < 3);
            seen = seen | busy | oe_out | done;
        end
        chk("len0_ignored", 32'(seen), 32'h0);

        start = 1'b1; seq_len = 5'd4; seed = 8'h01;
        tick();
        start = 1'b0;
        repeat (14) tick();
        reset = 1'b1;
        tick();
        chk("reset_mid", 32'(outs()), 32'h0);
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            seen = seen | done | busy;
        end
        chk("reset_mid_no_done", 32'(seen), 32'h0);

`ifdef ABORT_EN
        start = 1'b1; seq_len = 5'd4; seed = 8'h01;
        tick();
        start = 1'b0;
        repeat (9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", 32'({oe_out, step_idx, busy, done}), 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            seen = seen | done;
        end
        chk("abort_no_done", 32'(seen), 32'h0);

        start = 1'b1; abort = 1'b1; seq_len = 5'd4; seed = 8'h01;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_beats_abort", 32'(outs()), 32'({2'b01, 1'b1, 4'd0, 1'b1, 1'b0}));
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick();
            seen = !busy;
        end
        chk("start_abort_completes", 32'(seen), 32'h1);
        tick();

        run_seq(7, vecs[0], 1'b0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
